// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared types and constants for the APU responder: opcodes, flag bit positions,
// FSM states and the single-cycle ALU payload.
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_XLEN      = 32;
  localparam int unsigned APU_DIV_CNT_W = 5;

  localparam int unsigned APU_RFLAG_DZ  = 0;
  localparam int unsigned APU_RFLAG_ILL = 1;
  localparam int unsigned APU_RFLAG_OV  = 2;

  typedef enum logic [2:0] {
    APU_OP_ADD  = 3'd0,
    APU_OP_SUB  = 3'd1,
    APU_OP_MAC  = 3'd2,
    APU_OP_MIN  = 3'd3,
    APU_OP_MAX  = 3'd4,
    APU_OP_DIVU = 3'd5,
    APU_OP_REMU = 3'd6,
    APU_OP_RSVD = 3'd7
  } apu_resp_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    MUL    = 2'd2,
    DIV    = 2'd3
  } apu_resp_state_e;

  typedef struct packed {
    logic [APU_XLEN-1:0] result;
    logic                dz;
    logic                ill;
    logic                ov;
  } apu_alu_resp_t;

endpackage

// File: rtl/cv32e40p_apu_resp_div.sv
// Serial restoring divider: one quotient bit per cycle, 32 iterations after start.
// done_c and the *_c results are valid combinationally during the last iteration.
module cv32e40p_apu_resp_div
  import cv32e40p_apu_core_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [APU_XLEN-1:0]      dividend_i,
  input  logic [APU_XLEN-1:0]      divisor_i,
  output logic                     done_c,
  output logic [APU_XLEN-1:0]      quotient_c,
  output logic [APU_XLEN-1:0]      remainder_c,
  output logic [APU_DIV_CNT_W-1:0] cnt_o
);

  localparam logic [APU_DIV_CNT_W-1:0] CNT_LAST = APU_DIV_CNT_W'(APU_XLEN - 1);

  logic                     active_q, active_d;
  logic [APU_DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [APU_XLEN-1:0]      quo_q, quo_d;
  logic [APU_XLEN-1:0]      rem_q, rem_d;
  logic [APU_XLEN-1:0]      dvs_q, dvs_d;

  logic [APU_XLEN:0]        rem_sh;
  logic                     ge;
  logic [APU_XLEN-1:0]      rem_nxt;
  logic [APU_XLEN-1:0]      quo_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem_q, quo_q[APU_XLEN-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_nxt = ge ? APU_XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[APU_XLEN-1:0];
    quo_nxt = {quo_q[APU_XLEN-2:0], ge};
  end

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      quo_d    = dividend_i;
      rem_d    = '0;
      dvs_d    = divisor_i;
    end else if (active_q) begin
      quo_d = quo_nxt;
      rem_d = rem_nxt;
      if (cnt_q == CNT_LAST) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + APU_DIV_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
    end
  end

  assign done_c      = active_q && (cnt_q == CNT_LAST);
  assign quotient_c  = quo_nxt;
  assign remainder_c = rem_nxt;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/cv32e40p_apu_responder.sv
// APU-side responder: grants one request at a time, runs ALU/MAC/divide and
// returns the registered result with a one-cycle rvalid pulse.
module cv32e40p_apu_responder #(
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NUSFLAGS_CPU = 5,
  parameter int unsigned MUL_LAT          = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             apu_req_i,
  output logic                             apu_gnt_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]   apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]           apu_op_i,
  output logic                             apu_rvalid_o,
  output logic [31:0]                      apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]      apu_rflags_o,
  output logic                             busy_o
);

  import cv32e40p_apu_core_pkg::*;

  localparam int unsigned MAC_STAGES = MUL_LAT - 1;

  apu_resp_state_e                   state_q, state_d;
  logic                              rdy_q;
  logic                              rvalid_q, rvalid_d;
  logic [APU_XLEN-1:0]               result_q, result_d;
  logic [APU_NUSFLAGS_CPU-1:0]       rflags_q, rflags_d;
  logic                              busy_q;
  logic                              rem_sel_q, rem_sel_d;
  logic [MAC_STAGES-1:0][APU_XLEN-1:0] mac_q, mac_d;
  logic [MAC_STAGES-1:0]             mac_vld_q, mac_vld_d;

  apu_resp_op_e                      op_c;
  logic [APU_XLEN-1:0]               a_c, b_c, c_c, sum_c, diff_c, mac_c;
  logic                              gnt_c, mac_start_c, div_start_c;
  apu_alu_resp_t                     alu_c;
  logic [APU_NUSFLAGS_CPU-1:0]       alu_flags_c;

  logic                              div_done_c;
  logic [APU_XLEN-1:0]               div_quo_c, div_rem_c;
  logic [APU_DIV_CNT_W-1:0]          div_cnt;
  logic                              unused_bits;

  assign op_c   = apu_resp_op_e'(apu_op_i[2:0]);
  assign a_c    = apu_operands_i[0];
  assign b_c    = apu_operands_i[1];
  assign c_c    = apu_operands_i[2];
  assign sum_c  = a_c + b_c;
  assign diff_c = a_c - b_c;
  assign mac_c  = a_c * b_c + c_c;

  // rdy_q keeps the grant low until the first edge after reset release.
  assign gnt_c     = apu_req_i && rdy_q && (state_q == IDLE);
  assign apu_gnt_o = gnt_c;

  // Single-cycle ALU; divide entries only matter for the b==0 early-out.
  always_comb begin
    alu_c = '0;
    case (op_c)
      APU_OP_ADD: begin
        alu_c.result = sum_c;
        alu_c.ov     = (a_c[31] == b_c[31]) && (sum_c[31] != a_c[31]);
      end
      APU_OP_SUB: begin
        alu_c.result = diff_c;
        alu_c.ov     = (a_c[31] != b_c[31]) && (diff_c[31] != a_c[31]);
      end
      APU_OP_MIN:  alu_c.result = ($signed(a_c) < $signed(b_c)) ? a_c : b_c;
      APU_OP_MAX:  alu_c.result = ($signed(a_c) > $signed(b_c)) ? a_c : b_c;
      APU_OP_DIVU: begin
        alu_c.result = '1;
        alu_c.dz     = 1'b1;
      end
      APU_OP_REMU: begin
        alu_c.result = a_c;
        alu_c.dz     = 1'b1;
      end
      APU_OP_RSVD: alu_c.ill = 1'b1;
      default:     alu_c.result = mac_c;
    endcase
    alu_flags_c                = '0;
    alu_flags_c[APU_RFLAG_DZ]  = alu_c.dz;
    alu_flags_c[APU_RFLAG_ILL] = alu_c.ill;
    alu_flags_c[APU_RFLAG_OV]  = alu_c.ov;
  end

  // Single-cycle ops register on the granting edge, so SINGLE is passed through
  // in zero cycles and the responder is IDLE again in the rvalid cycle.
  always_comb begin
    state_d     = state_q;
    rvalid_d    = 1'b0;
    result_d    = result_q;
    rflags_d    = rflags_q;
    rem_sel_d   = rem_sel_q;
    mac_start_c = 1'b0;
    div_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_c) begin
          if (op_c == APU_OP_MAC) begin
            mac_start_c = 1'b1;
            state_d     = MUL;
          end else if (((op_c == APU_OP_DIVU) || (op_c == APU_OP_REMU)) && (b_c != '0)) begin
            div_start_c = 1'b1;
            rem_sel_d   = (op_c == APU_OP_REMU);
            state_d     = DIV;
          end else begin
            rvalid_d = 1'b1;
            result_d = alu_c.result;
            rflags_d = alu_flags_c;
            state_d  = IDLE;
          end
        end
      end
      MUL: begin
        if (mac_vld_q[MAC_STAGES-1]) begin
          rvalid_d = 1'b1;
          result_d = mac_q[MAC_STAGES-1];
          rflags_d = '0;
          state_d  = IDLE;
        end
      end
      DIV: begin
        if (div_done_c) begin
          rvalid_d = 1'b1;
          result_d = rem_sel_q ? div_rem_c : div_quo_c;
          rflags_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MAC delay line: MUL_LAT-1 stages before the output register.
  always_comb begin
    mac_d        = mac_q;
    mac_vld_d    = mac_vld_q;
    mac_d[0]     = mac_start_c ? mac_c : mac_q[0];
    mac_vld_d[0] = mac_start_c;
    for (int unsigned i = 1; i < MAC_STAGES; i++) begin
      mac_d[i]     = mac_q[i-1];
      mac_vld_d[i] = mac_vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      result_q  <= '0;
      rflags_q  <= '0;
      busy_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      mac_q     <= '0;
      mac_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      rvalid_q  <= rvalid_d;
      result_q  <= result_d;
      rflags_q  <= rflags_d;
      busy_q    <= (state_d != IDLE);
      rem_sel_q <= rem_sel_d;
      mac_q     <= mac_d;
      mac_vld_q <= mac_vld_d;
    end
  end

  cv32e40p_apu_resp_div u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start_c),
    .dividend_i  (a_c),
    .divisor_i   (b_c),
    .done_c      (div_done_c),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c),
    .cnt_o       (div_cnt)
  );

  assign apu_rvalid_o = rvalid_q;
  assign apu_result_o = result_q;
  assign apu_rflags_o = rflags_q;
  assign busy_o       = busy_q;

  assign unused_bits = ^{apu_op_i, apu_operands_i, div_cnt};

endmodule

// File: doc/cv32e40p_apu_responder.md
# cv32e40p_apu_responder

Shared-unit (APU) side of the core's auxiliary-processing-unit interconnect: grants requests issued by the execute stage, executes one integer operation at a time and returns the result with a single-cycle `apu_rvalid` pulse. It is a small, deterministic accelerator that lets the core's APU dispatch path be exercised without an FPU. Operations are strictly in order, one in flight.

## Interface
- `APU_NARGS_CPU`, 3: operand count; only operands 0..2 are used, so it must be at least 3.
- `APU_WOP_CPU`, 6: opcode width; only bits [2:0] are decoded, upper bits are ignored.
- `APU_NUSFLAGS_CPU`, 5: width of the response flags.
- `MUL_LAT`, 2: MAC latency in cycles; legal values are 2..4.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `apu_req_i`  in  1  request valid.
- `apu_gnt_o`  out  1  grant; combinational.
- `apu_operands_i`  in  [APU_NARGS_CPU][32]  operands a=[0], b=[1], c=[2].
- `apu_op_i`  in  APU_WOP_CPU  opcode.
- `apu_rvalid_o`  out  1  result valid, one-cycle pulse, no backpressure.
- `apu_result_o`  out  32  result.
- `apu_rflags_o`  out  APU_NUSFLAGS_CPU  status flags.
- `busy_o`  out  1  high when an operation is accepted and not yet returned.

## Operation
- Opcodes (`op[2:0]`):
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 MAC: low 32 bits of a*b+c, unsigned
  - 3 MIN: signed
  - 4 MAX: signed
  - 5 DIVU: a/b
  - 6 REMU: a%b
  - 7 reserved
- Flags:
  - bit0 DZ: DIVU/REMU with b=0.
  - bit1 ILL: op 7.
  - bit2 OV: signed overflow on ADD/SUB.
  - bits 3+ are always 0.
- Reserved op: result 0, ILL=1, single-cycle latency.
- Divide by zero:
  - Early out: DIVU returns 0xFFFFFFFF and REMU returns a.
  - DZ=1, single-cycle latency.
- DIVU/REMU use restoring division, one quotient bit per cycle, 32 iterations.
- FSM states:
  - IDLE → SINGLE: on grant of ADD/SUB/MIN/MAX, op 7, or a divide by zero.
  - IDLE → MUL: on grant of MAC.
  - IDLE → DIV: on grant of DIVU/REMU with b≠0.
  - SINGLE/MUL/DIV → IDLE: on the edge that registers the result.
- Grant:
  - `apu_gnt_o = apu_req_i & (state==IDLE)`.
  - Operands and op are captured on the granting edge. Later input changes have no effect.
- `busy_o` = state≠IDLE.
- `apu_rvalid_o`, `apu_result_o` and `apu_rflags_o` are registered.
  - `apu_result_o` and `apu_rflags_o` hold their last value when rvalid is low.
- Reset: every output is 0. The FSM goes to IDLE, the iteration counter to 0, and any in-flight operation is discarded with no rvalid.

## Timing
- Grant in cycle t gives `apu_rvalid_o`=1 in cycle:
  - t+1 for single-cycle ops, including divide by zero and ILL.
  - t+MUL_LAT for MAC.
  - t+33 for DIVU/REMU.
- In the rvalid cycle the state is already IDLE, so a new request is granted in that same cycle. A stream of single-cycle ops therefore runs at one per cycle.
- While the state is not IDLE, `apu_gnt_o`=0 regardless of `apu_req_i`. A held request is granted in the first IDLE cycle.
- Boundaries:
  - The iteration counter runs 0..31 with no wrap-around; it is reloaded on each DIV entry.
  - 32-bit arithmetic wraps modulo 2^32. OV only flags it, and the result is still the wrapped value.
  - `apu_req_i` asserted during reset deassertion: no grant until the first clock edge after `rst_n` rises. Grant is combinational, so it appears in the cycle after release.

## Structure
- Add to `cv32e40p_apu_core_pkg`:
  - enum `apu_resp_op_e` with the 8 opcodes.
  - constants `APU_RFLAG_DZ=0`, `APU_RFLAG_ILL=1`, `APU_RFLAG_OV=2`.
  - FSM enum `apu_resp_state_e` {IDLE, SINGLE, MUL, DIV}.
- Sub-module `cv32e40p_apu_resp_div`: serial restoring divider.
  - Ports: start, dividend, divisor, returns quotient and remainder.
  - done is a pulse after 32 iterations.
  - Provides the 5-bit counter.
- The MAC delay line (MUL_LAT−1 register stages) and the single-cycle ALU stay in the top module.

## Test plan
- ADD a=5, b=7 with req held one cycle → gnt=1 in cycle t; rvalid=1, result=12, flags=0 in t+1.
- Two back-to-back SUB ops (10−3, then 0−1) → grants in t and t+1; results 7 and 0xFFFFFFFF in t+1 and t+2, OV=0 for both.
- ADD 0x7FFFFFFF+1 → result 0x80000000, OV=1. MIN(−1, 3) → 0xFFFFFFFF.
- MAC a=3, b=4, c=5, MUL_LAT=2 → result 17 at t+2. A request held during t+1 sees gnt=0, then gnt=1 at t+2.
- DIVU 100/7 → gnt low and busy=1 for t+1..t+32; result 14 at t+33. REMU 100/7 → 2 at t+33. DIVU 9/0 → 0xFFFFFFFF with DZ=1 at t+1.
- Assert rst_n=0 at t+10 of a DIVU → all outputs 0, no rvalid ever. After reset release, an ADD 1+1 returns 2 one cycle after its grant.
